alu_seq_driver: RTL

- Sequential initiator for the team's combinational ALU. It drives alu_a, alu_b and alu_op into an external ALU instance and captures alu_out each cycle.
- Computes the n-th term of a generalised Fibonacci sequence from two seeds, using ADD operations only.
- Sits beside the ALU in the lab-1 datapath and replaces manual operand stepping from switches.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_seq_driver.sv | 137 +++++++++++++
 2 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcodes and sequencer state encoding.
// Imported by the ALU and by every block that drives it.
package alu_pkg;

   localparam logic [4:0] A_NOP = 5'h00;
   localparam logic [4:0] A_ADD = 5'h01;
   localparam logic [4:0] A_SUB = 5'h02;
   localparam logic [4:0] A_AND = 5'h03;
   localparam logic [4:0] A_OR  = 5'h04;
   localparam logic [4:0] A_XOR = 5'h05;
   localparam logic [4:0] A_NOR = 5'h06;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } seq_state_e;

endpackage

// File: rtl/alu_seq_driver.sv
// Generalised Fibonacci sequencer driving an external combinational ALU.
// Optional ALU_SEQ_OVF_EN: adds ovf port and aborts RUN on signed overflow.
module alu_seq_driver
   import alu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] f0,
   input  logic [DATA_W-1:0] f1,
   input  logic [CNT_W-1:0]  n,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [4:0]        alu_op,
`ifdef ALU_SEQ_OVF_EN
   output logic              ovf,
`endif
   input  logic [DATA_W-1:0] alu_out
);

   seq_state_e        state_q, state_d;
   logic [DATA_W-1:0] prev_q, prev_d;
   logic [DATA_W-1:0] cur_q, cur_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  target_q, target_d;
   logic [CNT_W:0]    cnt_inc;

   // One extra bit so n at its maximum cannot wrap before the compare.
   assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

`ifdef ALU_SEQ_OVF_EN
   logic ovf_q, ovf_d;
   logic ovf_det;

   assign ovf_det = (prev_q[DATA_W-1] == cur_q[DATA_W-1]) &&
                    (alu_out[DATA_W-1] != prev_q[DATA_W-1]);
   assign ovf     = ovf_q;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         prev_q   <= '0;
         cur_q    <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         target_q <= '0;
`ifdef ALU_SEQ_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         prev_q   <= prev_d;
         cur_q    <= cur_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         target_q <= target_d;
`ifdef ALU_SEQ_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      prev_d   = prev_q;
      cur_d    = cur_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      target_d = target_q;
`ifdef ALU_SEQ_OVF_EN
      ovf_d    = ovf_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               prev_d   = f0;
               cur_d    = f1;
               cnt_d    = CNT_W'(1);
               target_d = n;
`ifdef ALU_SEQ_OVF_EN
               ovf_d    = 1'b0;
`endif
               if (n == '0) begin
                  state_d  = S_DONE;
                  result_d = f0;
               end else if (n == CNT_W'(1)) begin
                  state_d  = S_DONE;
                  result_d = f1;
               end else begin
                  state_d  = S_RUN;
               end
            end
         end
         S_RUN: begin
            prev_d = cur_q;
            cur_d  = alu_out;
            cnt_d  = cnt_inc[CNT_W-1:0];
            if (cnt_inc == {1'b0, target_q}) begin
               state_d  = S_DONE;
               result_d = alu_out;
            end
`ifdef ALU_SEQ_OVF_EN
            if (ovf_det) begin
               ovf_d    = 1'b1;
               state_d  = S_DONE;
               result_d = alu_out;
            end
`endif
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy   = (state_q != S_IDLE);
      done   = (state_q == S_DONE);
      result = result_q;
      alu_a  = '0;
      alu_b  = '0;
      alu_op = A_NOP;
      if (state_q == S_RUN) begin
         alu_a  = prev_q;
         alu_b  = cur_q;
         alu_op = A_ADD;
      end
   end

endmodule
